// File: rtl/imem_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory read port, decode handshake, redirect and jump strobe.
// The fetch unit takes the master view; the memory/decode environment takes the slave view.
interface imem_fetch_unit_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        jump_taken;

  modport master (
    output imem_pc,
    input  imem_inst,
    output dec_valid,
    input  dec_ready,
    output dec_inst,
    output dec_pc,
    input  redirect_valid,
    input  redirect_target,
    output jump_taken
  );

  modport slave (
    input  imem_pc,
    output imem_inst,
    input  dec_valid,
    output dec_ready,
    input  dec_inst,
    input  dec_pc,
    output redirect_valid,
    output redirect_target,
    input  jump_taken
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction fetch requester: issues word PCs to a one-cycle-latency memory, buffers the
// returned words in a small FIFO for decode, and follows external redirects and J-type jumps.
module imem_fetch_unit #(
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned IMEM_DEPTH = 128,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_unit_if.master bus
);

  localparam int unsigned AW   = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCCW = CW + 1;

  localparam logic [5:0]      OP_J       = 6'b000010;
  localparam logic [AW-1:0]   RESET_PC_W = AW'(RESET_PC);
  localparam logic [PW-1:0]   PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [OCCW-1:0] DEPTH_W    = OCCW'(FIFO_DEPTH);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [AW-1:0] pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          jump_q, jump_d;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [AW-1:0] fifo_pc_q   [FIFO_DEPTH];

  logic            dec_valid_s;
  logic            dec_fire_s;
  logic            push_s;
  logic            resp_is_jump_s;
  logic            issue_ok_s;
  logic [OCCW-1:0] occ_s;
  logic [31:0]     jtarget_s;
  logic            unused_s;

  assign dec_valid_s = (count_q != '0);
  assign jtarget_s   = {6'b000000, bus.imem_inst[25:0]};
  assign unused_s    = ^{bus.redirect_target[31:AW], jtarget_s[31:AW]};

  // Priority: redirect flushes everything, then a jump response retargets, then sequential issue.
  always_comb begin
    dec_fire_s     = dec_valid_s & bus.dec_ready;
    resp_is_jump_s = inflight_q & (bus.imem_inst[31:26] == OP_J);
    occ_s          = OCCW'(count_q) + OCCW'(inflight_q) - OCCW'(dec_fire_s);
    issue_ok_s     = (occ_s < DEPTH_W);
    pc_d           = pc_q;
    inflight_d     = 1'b0;
    inflight_pc_d  = inflight_pc_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    push_s         = 1'b0;
    jump_d         = 1'b0;
    if (bus.redirect_valid) begin
      pc_d     = bus.redirect_target[AW-1:0];
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      push_s = inflight_q;
      if (resp_is_jump_s) begin
        pc_d   = jtarget_s[AW-1:0];
        jump_d = 1'b1;
      end else if (issue_ok_s) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + AW'(1);
      end else begin
        pc_d = pc_q;
      end
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (dec_fire_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(dec_fire_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC_W;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      jump_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      jump_q        <= jump_d;
    end
  end

  // Payload storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      fifo_inst_q[wr_ptr_q] <= bus.imem_inst;
      fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign bus.imem_pc    = 32'(pc_q);
  assign bus.dec_valid  = dec_valid_s;
  assign bus.dec_inst   = dec_valid_s ? fifo_inst_q[rd_ptr_q] : 32'h0000_0000;
  assign bus.dec_pc     = dec_valid_s ? 32'(fifo_pc_q[rd_ptr_q]) : 32'h0000_0000;
  assign bus.jump_taken = jump_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: latency, jump, back-pressure, reset, wrap and redirect.
module tb_imem_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  logic [31:0] mem [128];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_fetch_unit_if bus ();
  imem_fetch_unit_if bus2 ();

  imem_fetch_unit #(.RESET_PC(0), .IMEM_DEPTH(128), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  imem_fetch_unit #(.RESET_PC(126), .IMEM_DEPTH(128), .FIFO_DEPTH(3)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.master)
  );

  // One-cycle-latency instruction memories
  always @(posedge clk) begin
    bus.imem_inst  <= mem[bus.imem_pc[6:0]];
    bus2.imem_inst <= mem[bus2.imem_pc[6:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("fifo_no_overflow", 32'(dut.count_q <= 2'd2), 32'd1);
    chk("fifo2_no_overflow", 32'(dut2.count_q <= 2'd3), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[6] = 32'h0801_1020;
    rst  = 1'b1;
    rst2 = 1'b1;
    bus.dec_ready        = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_target  = 32'd0;
    bus2.dec_ready       = 1'b0;
    bus2.redirect_valid  = 1'b0;
    bus2.redirect_target = 32'd0;
    repeat (2) tick();

    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_dec_inst", bus.dec_inst, 32'd0);
    chk("rst_dec_pc", bus.dec_pc, 32'd0);
    chk("rst_imem_pc", bus.imem_pc, 32'd0);
    chk("rst_jump", 32'(bus.jump_taken), 32'd0);
    chk("rst2_imem_pc", bus2.imem_pc, 32'd126);

    // Streaming from reset; cycle 0 is this one
    rst = 1'b0;
    bus.dec_ready = 1'b1;
    tick();
    chk("lat_c1_valid", 32'(bus.dec_valid), 32'd0);
    for (int k = 0; k <= 6; k++) begin
      tick();
      chk("seq_valid", 32'(bus.dec_valid), 32'd1);
      chk("seq_pc", bus.dec_pc, 32'(k));
      chk("seq_inst", bus.dec_inst, mem[k]);
      chk("seq_jump", 32'(bus.jump_taken), (k == 6) ? 32'd1 : 32'd0);
    end
    chk("jump_imem_pc", bus.imem_pc, 32'd32);
    tick();
    chk("jump_pulse_end", 32'(bus.jump_taken), 32'd0);
    chk("jump_gap_valid", 32'(bus.dec_valid), 32'd0);
    tick();
    chk("jump_tgt_pc", bus.dec_pc, 32'd32);
    chk("jump_tgt_inst", bus.dec_inst, mem[32]);
    tick();
    chk("jump_tgt_pc1", bus.dec_pc, 32'd33);

    // Fill the FIFO, then reset mid-stream
    bus.dec_ready = 1'b0;
    repeat (2) tick();
    chk("full_valid", 32'(bus.dec_valid), 32'd1);
    chk("full_pc", bus.dec_pc, 32'd33);
    chk("full_imem_pc", bus.imem_pc, 32'd35);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(bus.dec_valid), 32'd0);
    chk("midrst_pc", bus.dec_pc, 32'd0);
    chk("midrst_imem_pc", bus.imem_pc, 32'd0);
    chk("midrst_jump", 32'(bus.jump_taken), 32'd0);

    // Restart with decode stalled for five cycles after the first valid
    rst = 1'b0;
    tick();
    chk("stall_c1_valid", 32'(bus.dec_valid), 32'd0);
    chk("stall_c1_imem_pc", bus.imem_pc, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", 32'(bus.dec_valid), 32'd1);
      chk("stall_pc", bus.dec_pc, 32'd0);
      chk("stall_inst", bus.dec_inst, mem[0]);
      chk("stall_imem_pc", bus.imem_pc, 32'd2);
    end
    tick();
    chk("release_pc0", bus.dec_pc, 32'd0);
    bus.dec_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("release_valid", 32'(bus.dec_valid), 32'd1);
      chk("release_pc", bus.dec_pc, 32'(k));
      chk("release_inst", bus.dec_inst, mem[k]);
    end
    bus.dec_ready = 1'b0;

    // Wrap from RESET_PC=126 on the deeper instance
    rst2 = 1'b0;
    bus2.dec_ready = 1'b1;
    tick();
    chk("wrap_c1_valid", 32'(bus2.dec_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wrap_valid", 32'(bus2.dec_valid), 32'd1);
      chk("wrap_pc", bus2.dec_pc, 32'((126 + k) % 128));
      chk("wrap_inst", bus2.dec_inst, mem[(126 + k) % 128]);
    end

    // Redirect with two entries buffered and one request in flight
    bus2.dec_ready = 1'b0;
    tick();
    chk("pre_redir_pc", bus2.dec_pc, 32'd1);
    chk("pre_redir_imem_pc", bus2.imem_pc, 32'd4);
    bus2.redirect_valid  = 1'b1;
    bus2.redirect_target = 32'd100;
    tick();
    chk("redir_flush_valid", 32'(bus2.dec_valid), 32'd0);
    chk("redir_imem_pc", bus2.imem_pc, 32'd100);
    bus2.redirect_valid = 1'b0;
    bus2.dec_ready      = 1'b1;
    tick();
    chk("redir_drop_valid", 32'(bus2.dec_valid), 32'd0);
    tick();
    chk("redir_pc100", bus2.dec_pc, 32'd100);
    chk("redir_inst100", bus2.dec_inst, mem[100]);
    tick();
    chk("redir_pc101", bus2.dec_pc, 32'd101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
